conv_pad_scheduler: RTL and testbench

Frame sequencer in front of one 8-channel convolution feature-map stage. Pops one pixel per channel from the per-channel show-ahead input FIFOs and emits a zero-padded (WIDTH+2)×(HEIGHT+2) raster stream to the channel conv2D line buffers. Inserts the one-pixel zero border itself, so padding occupies no FIFO space. Counts result pulses returned by the feature-map stage and reports frame completion.

---
 rtl/conv_pad_if.sv | 24 ++
 rtl/conv_pad_scheduler.sv | 101 ++++++++++
 tb/tb_conv_pad_scheduler.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_pad_if.sv
// conv_pad_if: handshake bundle between a frame driver and conv_pad_scheduler.
//   start       driver -> scheduler  begin one frame
//   fifo_empty  driver -> scheduler  per-channel FIFO empty flags
//   fifo_data   driver -> scheduler  per-channel FIFO head words, channel c at [c*DATA_WIDTH +: DATA_WIDTH]
//   res_valid   driver -> scheduler  one pulse per computed output pixel
//   fifo_rdreq  scheduler -> driver  shared pop strobe
//   pix_data    scheduler -> driver  padded pixel per channel
//   pix_valid   scheduler -> driver  pix_data valid
//   busy, done  scheduler -> driver  frame status
interface conv_pad_if #(parameter int NUM_CH = 8, parameter int DATA_WIDTH = 32);
  logic                         start;
  logic [NUM_CH-1:0]            fifo_empty;
  logic [NUM_CH*DATA_WIDTH-1:0] fifo_data;
  logic                         fifo_rdreq;
  logic [NUM_CH*DATA_WIDTH-1:0] pix_data;
  logic                         pix_valid;
  logic                         res_valid;
  logic                         busy;
  logic                         done;
  modport master (output start, fifo_empty, fifo_data, res_valid,
                  input  fifo_rdreq, pix_data, pix_valid, busy, done);
  modport slave  (input  start, fifo_empty, fifo_data, res_valid,
                  output fifo_rdreq, pix_data, pix_valid, busy, done);
endinterface

// File: rtl/conv_pad_scheduler.sv
// conv_pad_scheduler: streams a zero-bordered (WIDTH+2)x(HEIGHT+2) frame from per-channel FIFOs and tracks result pulses.
//   clk  rising-edge clock
//   rst  asynchronous active-low reset
//   io   conv_pad_if slave: start/fifo_empty/fifo_data/res_valid in, fifo_rdreq (combinational),
//        pix_data/pix_valid/busy/done out (registered)
module conv_pad_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int WIDTH      = 112,
  parameter int HEIGHT     = 112,
  parameter int NUM_CH     = 8
) (
  input logic       clk,
  input logic       rst,
  conv_pad_if.slave io
);
  localparam int CW  = $clog2(WIDTH + 2);
  localparam int RW  = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam int PIX = WIDTH * HEIGHT;
  localparam int NW  = $clog2(PIX + 1);
  localparam logic [CW-1:0] COL_PAD  = CW'(WIDTH + 1);
  localparam logic [CW-1:0] COL_MID  = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [NW-1:0] RES_ALL  = NW'(PIX);
  typedef enum logic [2:0] {IDLE, PAD_TOP, ROW_L, ROW_MID, ROW_R, PAD_BOT, DRAIN, DONE} state_t;
  state_t                       state;
  logic [CW-1:0]                col;
  logic [RW-1:0]                row;
  logic [NW-1:0]                res_cnt;
  logic                         zero_beat;
  logic [NUM_CH*DATA_WIDTH-1:0] head;
  assign head          = io.fifo_data;
  // A pop needs every channel to have a word, so all lanes stay aligned.
  assign io.fifo_rdreq = state == ROW_MID && ~|io.fifo_empty;
  assign zero_beat     = state inside {PAD_TOP, ROW_L, ROW_R, PAD_BOT};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      res_cnt      <= '0;
      io.pix_valid <= 1'b0;
      io.pix_data  <= '0;
      io.busy      <= 1'b0;
      io.done      <= 1'b0;
    end else begin
      io.pix_valid <= zero_beat || io.fifo_rdreq;
      io.pix_data  <= io.fifo_rdreq ? head : '0;
      // Results may return while the frame is still streaming; cap at one per pixel.
      if (state != IDLE && io.res_valid && res_cnt != RES_ALL) res_cnt <= res_cnt + 1'b1;
      case (state)
        IDLE: begin
          col     <= '0;
          row     <= '0;
          res_cnt <= '0;
          if (io.start) begin
            state   <= PAD_TOP;
            io.busy <= 1'b1;
          end
        end
        PAD_TOP: begin
          col <= col == COL_PAD ? '0 : col + 1'b1;
          if (col == COL_PAD) begin
            state <= ROW_L;
            row   <= '0;
          end
        end
        ROW_L: begin
          col   <= '0;
          state <= ROW_MID;
        end
        ROW_MID:
          if (io.fifo_rdreq) begin
            col <= col + 1'b1;
            if (col == COL_MID) state <= ROW_R;
          end
        ROW_R: begin
          col <= '0;
          if (row == ROW_LAST) state <= PAD_BOT;
          else begin
            row   <= row + 1'b1;
            state <= ROW_L;
          end
        end
        PAD_BOT: begin
          col <= col == COL_PAD ? '0 : col + 1'b1;
          if (col == COL_PAD) state <= DRAIN;
        end
        DRAIN:
          if (res_cnt == RES_ALL) begin
            state   <= DONE;
            io.done <= 1'b1;
          end
        DONE: begin
          io.done <= 1'b0;
          io.busy <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_conv_pad_scheduler.sv
// tb_conv_pad_scheduler: directed frames on a 4x3 instance and a full-size 112x112 instance.
module tb_conv_pad_scheduler;
  localparam int SW = 4, SH = 3, BW = 112, BH = 112;
  localparam int S_BEATS = (SW + 2) * (SH + 2), B_BEATS = (BW + 2) * (BH + 2);
  logic clk = 1'b0, rst = 1'b0;
  int checks = 0, fails = 0, cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  conv_pad_if #(.NUM_CH(8), .DATA_WIDTH(32)) s_if ();
  conv_pad_if #(.NUM_CH(8), .DATA_WIDTH(32)) b_if ();
  conv_pad_scheduler #(.DATA_WIDTH(32), .WIDTH(SW), .HEIGHT(SH), .NUM_CH(8)) dut_s (.clk(clk), .rst(rst), .io(s_if));
  conv_pad_scheduler #(.DATA_WIDTH(32), .WIDTH(BW), .HEIGHT(BH), .NUM_CH(8)) dut_b (.clk(clk), .rst(rst), .io(b_if));

  task automatic chk_v(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: padded beat k of a w x h frame; interior pixel i of channel ch is ch*16+i.
  function automatic logic [255:0] exp_beat(int k, int w, int h);
    logic [255:0] v;
    int r, c;
    r = k / (w + 2);
    c = k % (w + 2);
    v = '0;
    if (r > 0 && r <= h && c > 0 && c <= w)
      for (int ch = 0; ch < 8; ch++) v[ch*32 +: 32] = 32'(ch * 16 + (r - 1) * w + c - 1);
    return v;
  endfunction

  // FIFO sources: head word advances on each pop, refilled when a frame is accepted.
  logic [31:0] s_ptr, b_ptr;
  always @(posedge clk)
    if (!rst || (s_if.start && !s_if.busy)) s_ptr <= '0;
    else if (s_if.fifo_rdreq) s_ptr <= s_ptr + 1;
  always @(posedge clk)
    if (!rst || (b_if.start && !b_if.busy)) b_ptr <= '0;
    else if (b_if.fifo_rdreq) b_ptr <= b_ptr + 1;
  always_comb begin
    s_if.fifo_data = '0;
    b_if.fifo_data = '0;
    for (int c = 0; c < 8; c++) begin
      s_if.fifo_data[c*32 +: 32] = 32'(c * 16) + s_ptr;
      b_if.fifo_data[c*32 +: 32] = 32'(c * 16) + b_ptr;
    end
  end
  // Large instance: one result returned per popped pixel, a cycle later.
  always @(posedge clk) b_if.res_valid <= rst && b_if.fifo_rdreq;

  // Compare processes.
  int s_beats, s_pops, s_first, s_last, s_done_n, s_done_cyc;
  logic [255:0] s_cap [S_BEATS];
  always @(negedge clk)
    if (rst) begin
      if (s_if.start && !s_if.busy) begin
        s_beats  <= 0;
        s_pops   <= 0;
        s_done_n <= 0;
      end else begin
        if (s_if.fifo_rdreq) s_pops <= s_pops + 1;
        if (s_if.pix_valid) begin
          if (s_beats == 0) s_first <= cyc;
          s_last <= cyc;
          chk_v("s_beat", s_if.pix_data, s_beats < S_BEATS ? exp_beat(s_beats, SW, SH) : '1);
          if (s_beats < S_BEATS) s_cap[s_beats] <= s_if.pix_data;
          s_beats <= s_beats + 1;
        end
        if (s_if.done) begin
          s_done_n   <= s_done_n + 1;
          s_done_cyc <= cyc;
        end
      end
    end
  int b_beats, b_pops, b_res, b_first, b_last, b_done_n;
  always @(negedge clk)
    if (rst) begin
      if (b_if.start && !b_if.busy) begin
        b_beats  <= 0;
        b_pops   <= 0;
        b_res    <= 0;
        b_done_n <= 0;
      end else begin
        if (b_if.fifo_rdreq) b_pops <= b_pops + 1;
        if (b_if.res_valid) b_res <= b_res + 1;
        if (b_if.pix_valid) begin
          if (b_beats == 0) b_first <= cyc;
          b_last <= cyc;
          if (b_if.pix_data !== (b_beats < B_BEATS ? exp_beat(b_beats, BW, BH) : '1))
            chk_v("b_beat", b_if.pix_data, b_beats < B_BEATS ? exp_beat(b_beats, BW, BH) : '1);
          else checks++;
          b_beats <= b_beats + 1;
        end
        if (b_if.done) b_done_n <= b_done_n + 1;
      end
    end

  task automatic start_s();
    @(posedge clk); #1;
    s_if.start = 1'b1;
    chk_i("idle_busy", int'(s_if.busy), 0);
    chk_i("idle_done", int'(s_if.done), 0);
    @(posedge clk); #1;
    s_if.start = 1'b0;
  endtask
  task automatic s_res(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      s_if.res_valid = 1'b1;
    end
    @(posedge clk); #1;
    s_if.res_valid = 1'b0;
  endtask
  task automatic wait_ptr(input int n);
    int i;
    for (i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (s_ptr >= 32'(n)) break;
    end
    chk_i("ptr_timeout", int'(i < 100), 1);
  endtask
  task automatic wait_s_beats(input int n);
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (s_beats >= n) break;
    end
    chk_i("beats_timeout", int'(i < 200), 1);
  endtask
  task automatic wait_s_done();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge clk); #1;
      if (s_done_n > 0) break;
    end
    chk_i("done_timeout", int'(i < 200), 1);
  endtask
  task automatic chk_idle_outputs(input string tag);
    chk_i({tag, "_pix_valid"}, int'(s_if.pix_valid), 0);
    chk_v({tag, "_pix_data"}, s_if.pix_data, '0);
    chk_i({tag, "_done"}, int'(s_if.done), 0);
    chk_i({tag, "_busy"}, int'(s_if.busy), 0);
    chk_i({tag, "_rdreq"}, int'(s_if.fifo_rdreq), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.start = 1'b0; s_if.fifo_empty = '0; s_if.res_valid = 1'b0;
    b_if.start = 1'b0; b_if.fifo_empty = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_idle_outputs("reset");
    chk_i("reset_b_busy", int'(b_if.busy), 0);
    @(negedge clk) rst = 1'b1;

    // Basic frame; 14 results during the stream, extras ignored, DRAIN one cycle.
    start_s();
    wait_ptr(1);
    s_res(14);
    wait_s_done();
    chk_i("basic_beats", s_beats, S_BEATS);
    chk_i("basic_pops", s_pops, SW * SH);
    chk_i("basic_span", s_last - s_first + 1, S_BEATS);
    chk_i("basic_drain1", s_done_cyc, s_last + 1);
    chk_i("basic_done_n", s_done_n, 1);
    chk_i("basic_busy_at_done", int'(s_if.busy), 1);
    chk_v("pin_b6", s_cap[6], '0);
    chk_i("pin_b7_ch1", int'(s_cap[7][63:32]), 16);
    chk_i("pin_b10_ch7", int'(s_cap[10][255:224]), 115);
    chk_i("pin_b13_ch2", int'(s_cap[13][95:64]), 36);
    chk_i("pin_b22_ch3", int'(s_cap[22][127:96]), 59);
    chk_v("pin_b29", s_cap[29], '0);

    // Back-to-back start; stall on channel 5 at pixel 5; last result 5 cycles after PAD_BOT.
    start_s();
    s_res(11);
    wait_ptr(5);
    s_if.fifo_empty[5] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_i("stall_rdreq", int'(s_if.fifo_rdreq), 0);
      if (i > 0) chk_i("stall_pix_valid", int'(s_if.pix_valid), 0);
    end
    @(posedge clk); #1;
    s_if.fifo_empty[5] = 1'b0;
    @(negedge clk);
    chk_i("stall_pix_valid", int'(s_if.pix_valid), 0);
    wait_s_beats(S_BEATS);
    repeat (4) @(posedge clk);
    #1 s_if.res_valid = 1'b1;
    @(posedge clk);
    #1 s_if.res_valid = 1'b0;
    wait_s_done();
    chk_i("late_done_cyc", s_done_cyc, s_last + 6);
    chk_i("stall_beats", s_beats, S_BEATS);
    chk_i("stall_pops", s_pops, SW * SH);
    chk_i("late_busy_at_done", int'(s_if.busy), 1);
    @(negedge clk); #1;
    chk_i("late_busy_after", int'(s_if.busy), 0);
    chk_i("late_done_after", int'(s_if.done), 0);

    // Start while busy is ignored, then reset mid-row.
    start_s();
    wait_ptr(2);
    s_if.start = 1'b1;
    @(posedge clk); #1;
    s_if.start = 1'b0;
    chk_i("restart_busy", int'(s_if.busy), 1);
    #3 rst = 1'b0;
    #1 chk_idle_outputs("midreset");
    repeat (2) @(negedge clk);
    chk_idle_outputs("midreset_hold");
    chk_i("midreset_no_done", s_done_n, 0);
    rst = 1'b1;
    start_s();
    s_res(12);
    wait_s_done();
    chk_i("fresh_beats", s_beats, S_BEATS);
    chk_i("fresh_pops", s_pops, SW * SH);
    chk_i("fresh_span", s_last - s_first + 1, S_BEATS);
    chk_i("fresh_done_n", s_done_n, 1);

    // Full-size frame.
    @(posedge clk); #1;
    b_if.start = 1'b1;
    @(posedge clk); #1;
    b_if.start = 1'b0;
    begin
      int i;
      for (i = 0; i < 14000; i++) begin
        @(negedge clk); #1;
        if (b_done_n > 0) break;
      end
      chk_i("big_done_timeout", int'(i < 14000), 1);
    end
    chk_i("big_beats", b_beats, B_BEATS);
    chk_i("big_pops", b_pops, BW * BH);
    chk_i("big_res", b_res, BW * BH);
    chk_i("big_span", b_last - b_first + 1, B_BEATS);
    chk_i("big_done_n", b_done_n, 1);
    repeat (3) @(negedge clk);
    chk_i("big_busy_after", int'(b_if.busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
